// File: rtl/prog_loader.sv
// Boot loader: parses an A5/length/payload frame from the UART and writes 16-bit words to program RAM.
// Optional trailing checksum byte is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int BITS         = 16,
  parameter int ADDRESS_BITS = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [7:0]              RX_DATA,
  input  logic                    RX_VALID,
  output logic                    RX_READY,
  output logic [ADDRESS_BITS-1:0] MEM_ADDRESS,
  output logic [BITS-1:0]         MEM_DATA_OUT,
  output logic                    MEM_WR,
  output logic                    CPU_HOLD,
  output logic                    DONE,
  output logic                    ERROR
);

  localparam logic [7:0]  SYNC     = 8'hA5;
  localparam logic [16:0] CAPACITY = 17'(1) << ADDRESS_BITS;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERROR
  } state_t;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t AFTER_PAYLOAD = S_CHK;
`else
  localparam state_t AFTER_PAYLOAD = S_DONE;
`endif

  state_t                  state;
  state_t                  state_next;
  logic [15:0]             len;
  logic [ADDRESS_BITS-1:0] counter;
  logic [7:0]              hi_byte;
  logic                    accept;
  logic [15:0]             len_full;
  logic [16:0]             count_plus;
  logic                    len_too_big;
  logic                    len_zero;
  logic                    last_word;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]              sum;
`endif

  assign accept      = RX_VALID && RX_READY;
  assign len_full    = {len[15:8], RX_DATA};
  assign len_too_big = {1'b0, len_full} > CAPACITY;
  assign len_zero    = (len_full == 16'd0);
  assign count_plus  = 17'(counter) + 17'd1;
  assign last_word   = (count_plus == {1'b0, len});

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) begin
      unique case (state)
        S_IDLE:    if (RX_DATA == SYNC) state_next = S_LEN_HI;
        S_LEN_HI:  state_next = S_LEN_LO;
        S_LEN_LO: begin
          if (len_too_big)   state_next = S_ERROR;
          else if (len_zero) state_next = AFTER_PAYLOAD;
          else               state_next = S_DATA_HI;
        end
        S_DATA_HI: state_next = S_DATA_LO;
        S_DATA_LO: state_next = last_word ? AFTER_PAYLOAD : S_DATA_HI;
`ifdef PROG_LOADER_CHECKSUM_EN
        S_CHK:     state_next = (RX_DATA == sum) ? S_DONE : S_ERROR;
`endif
        S_DONE, S_ERROR: if (RX_DATA == SYNC) state_next = S_LEN_HI;
        default:   state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    RX_READY = !MEM_WR;
    DONE     = (state == S_DONE);
    ERROR    = (state == S_ERROR);
    CPU_HOLD = (state != S_DONE);
  end

  // The high byte is staged separately so the write port stays stable until the next write.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      len          <= '0;
      counter      <= '0;
      hi_byte      <= '0;
      MEM_ADDRESS  <= '0;
      MEM_DATA_OUT <= '0;
      MEM_WR       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum          <= '0;
`endif
    end else begin
      MEM_WR <= 1'b0;
      if (accept) begin
        unique case (state)
          S_LEN_HI: len[15:8] <= RX_DATA;
          S_LEN_LO: begin
            len[7:0] <= RX_DATA;
            counter  <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum      <= '0;
`endif
          end
          S_DATA_HI: begin
            hi_byte <= RX_DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum     <= sum + RX_DATA;
`endif
          end
          S_DATA_LO: begin
            MEM_DATA_OUT <= {hi_byte, RX_DATA};
            MEM_ADDRESS  <= counter;
            MEM_WR       <= 1'b1;
            counter      <= counter + ADDRESS_BITS'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
            sum          <= sum + RX_DATA;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule
